// File: rtl/pipelined_cla_adder_pkg.sv
// Shared configuration, helpers and stage-record layout for the pipelined
// carry-lookahead adder/subtractor.
package pipelined_cla_adder_pkg;

  localparam int unsigned WIDTH_DEF = 64;
  localparam int unsigned SEG_DEF   = 16;

  function automatic int unsigned nseg(input int unsigned width, input int unsigned seg);
    return width / seg;
  endfunction

  function automatic bit width_ok(input int unsigned width, input int unsigned seg);
    return (seg != 0) && (width >= seg) && ((width % seg) == 0);
  endfunction

  localparam int unsigned NSEG_DEF = nseg(WIDTH_DEF, SEG_DEF);

  // Record carried between stages for the default configuration; the top
  // declares the same layout at its own elaborated width.
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [WIDTH_DEF-1:0] sum_lo;
    logic [WIDTH_DEF-1:0] a_hi;
    logic [WIDTH_DEF-1:0] b_hi;
    logic                 a_msb;
    logic                 b_msb;
    logic                 ovf;
  } stage_t;

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result valid-ready bus of the pipelined adder.
interface pipelined_cla_adder_if
  import pipelined_cla_adder_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/pipelined_cla_adder_cla_segment.sv
// Combinational SEG-bit carry-lookahead block: every internal carry is a
// flat sum-of-products of gen/prop terms, no ripple chain.
module cla_segment #(
  parameter int unsigned SEG = 16
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           g,
  output logic           p
);
  logic [SEG-1:0] gen;
  logic [SEG-1:0] prop;
  logic [SEG-1:0] c;

  assign gen  = a & b;
  assign prop = a ^ b;

  always_comb begin
    logic term;
    logic acc;
    term = 1'b0;
    acc  = 1'b0;
    c    = '0;
    c[0] = cin;
    for (int i = 1; i < int'(SEG); i++) begin
      acc = cin;
      for (int j = 0; j < i; j++) acc = acc & prop[j];
      for (int j = 0; j < i; j++) begin
        term = gen[j];
        for (int m = j + 1; m < i; m++) term = term & prop[m];
        acc = acc | term;
      end
      c[i] = acc;
    end
    g = 1'b0;
    for (int j = 0; j < int'(SEG); j++) begin
      term = gen[j];
      for (int m = j + 1; m < int'(SEG); m++) term = term & prop[m];
      g = g | term;
    end
    p    = &prop;
    cout = g | (p & cin);
    sum  = prop ^ c;
  end
endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined WIDTH-bit adder/subtractor: one SEG-bit lookahead segment per
// stage, carry registered between stages, whole pipe stalls on backpressure.
module pipelined_cla_adder
  import pipelined_cla_adder_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned SEG   = SEG_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  pipelined_cla_adder_if.slave bus
);
  localparam int unsigned NSEG = nseg(WIDTH, SEG);

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] sum_lo;
    logic [WIDTH-1:0] a_hi;
    logic [WIDTH-1:0] b_hi;
    logic             a_msb;
    logic             b_msb;
    logic             ovf;
  } stage_rec_t;

  if (!width_ok(WIDTH, SEG)) begin : g_width_check
    $error("pipelined_cla_adder: WIDTH must be a nonzero multiple of SEG");
  end

  logic       adv;
  stage_rec_t last_q;

  assign adv           = !last_q.valid | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = last_q.valid;
  assign bus.out_sum   = last_q.sum_lo;
  assign bus.out_cout  = last_q.carry;
  assign bus.out_ovf   = last_q.ovf;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    stage_rec_t     in_rec;
    stage_rec_t     d;
    stage_rec_t     q;
    logic [SEG-1:0] seg_sum;
    logic           seg_cout;

    if (k == 0) begin : g_entry
      // Subtraction folds into addition: A + ~B + ~borrow_in.
      always_comb begin
        in_rec       = '0;
        in_rec.valid = bus.in_valid;
        in_rec.carry = bus.in_sub ? ~bus.in_cin : bus.in_cin;
        in_rec.a_hi  = bus.in_a;
        in_rec.b_hi  = bus.in_sub ? ~bus.in_b : bus.in_b;
        in_rec.a_msb = bus.in_a[WIDTH-1];
        in_rec.b_msb = in_rec.b_hi[WIDTH-1];
      end
    end else begin : g_link
      assign in_rec = g_stage[k-1].q;
    end

    cla_segment #(.SEG(SEG)) u_seg (
      .a    (in_rec.a_hi[k*SEG +: SEG]),
      .b    (in_rec.b_hi[k*SEG +: SEG]),
      .cin  (in_rec.carry),
      .sum  (seg_sum),
      .cout (seg_cout),
      .g    (),
      .p    ()
    );

    // Retire this slice: deposit its sum bits, drop its operand bits.
    always_comb begin
      d                        = in_rec;
      d.sum_lo[k*SEG +: SEG]   = seg_sum;
      d.a_hi[k*SEG +: SEG]     = '0;
      d.b_hi[k*SEG +: SEG]     = '0;
      d.carry                  = seg_cout;
      if (k == NSEG - 1) begin
        d.ovf = (in_rec.a_msb == in_rec.b_msb) & (d.sum_lo[WIDTH-1] != in_rec.a_msb);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        q <= '0;
      end else if (adv) begin
        q <= d;
      end
    end
  end

  assign last_q = g_stage[NSEG-1].q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Randomised scoreboard bench for three configurations of the pipelined
// adder (64/16, 8/8, 12/4) against a plain-arithmetic reference model.
module tb_pipelined_cla_adder;
  import pipelined_cla_adder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst8, rst12;
  logic done8 = 1'b0, done12 = 1'b0;
  int   total = 0, bad = 0;

  pipelined_cla_adder_if #(.WIDTH(64)) b64 ();
  pipelined_cla_adder_if #(.WIDTH(8))  b8 ();
  pipelined_cla_adder_if #(.WIDTH(12)) b12 ();

  pipelined_cla_adder #(.WIDTH(64), .SEG(16)) dut64 (.clk(clk), .rst(rst),   .bus(b64));
  pipelined_cla_adder #(.WIDTH(8),  .SEG(8))  dut8  (.clk(clk), .rst(rst8),  .bus(b8));
  pipelined_cla_adder #(.WIDTH(12), .SEG(4))  dut12 (.clk(clk), .rst(rst12), .bus(b12));

  logic [65:0] q64[$], q8[$], q12[$];

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {ovf, cout, sum} of a w-bit add/sub using whole-number arithmetic.
  function automatic logic [65:0] ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                                            input logic cin, input logic sub);
    logic [67:0] mask, ua, ub, u;
    logic signed [67:0] one, sa, sb, r, smax, smin;
    logic co, ov;
    one  = 68'sd1;
    mask = (68'd1 << w) - 68'd1;
    ua   = {4'd0, a} & mask;
    ub   = {4'd0, b} & mask;
    sa   = ua[w-1] ? $signed(ua) - (one <<< w) : $signed(ua);
    sb   = ub[w-1] ? $signed(ub) - (one <<< w) : $signed(ub);
    smax = (one <<< (w - 1)) - one;
    smin = -(one <<< (w - 1));
    if (!sub) begin
      u  = ua + ub + 68'(cin);
      co = u[w];
      r  = sa + sb + $signed({67'd0, cin});
    end else begin
      u  = ua - ub - 68'(cin);
      co = (ua >= ub + 68'(cin));
      r  = sa - sb - $signed({67'd0, cin});
    end
    ov = (r > smax) || (r < smin);
    return {ov, co, 64'(u & mask)};
  endfunction

  // Scoreboards: compare the head whenever a result is presented, pop on transfer.
  always @(negedge clk) begin
    if (rst) q64.delete();
    else begin
      if (b64.out_valid) begin
        if (q64.size() == 0) check("m64_spurious", 66'(b64.out_valid), 66'd0);
        else begin
          check("m64_out", {b64.out_ovf, b64.out_cout, b64.out_sum}, q64[0]);
          if (b64.out_ready) void'(q64.pop_front());
        end
      end
      if (b64.in_valid && b64.in_ready)
        q64.push_back(ref_model(64, b64.in_a, b64.in_b, b64.in_cin, b64.in_sub));
    end
  end

  always @(negedge clk) begin
    if (rst8) q8.delete();
    else begin
      if (b8.out_valid) begin
        if (q8.size() == 0) check("m8_spurious", 66'(b8.out_valid), 66'd0);
        else begin
          check("m8_out", {b8.out_ovf, b8.out_cout, 64'(b8.out_sum)}, q8[0]);
          if (b8.out_ready) void'(q8.pop_front());
        end
      end
      if (b8.in_valid && b8.in_ready)
        q8.push_back(ref_model(8, 64'(b8.in_a), 64'(b8.in_b), b8.in_cin, b8.in_sub));
    end
  end

  always @(negedge clk) begin
    if (rst12) q12.delete();
    else begin
      if (b12.out_valid) begin
        if (q12.size() == 0) check("m12_spurious", 66'(b12.out_valid), 66'd0);
        else begin
          check("m12_out", {b12.out_ovf, b12.out_cout, 64'(b12.out_sum)}, q12[0]);
          if (b12.out_ready) void'(q12.pop_front());
        end
      end
      if (b12.in_valid && b12.in_ready)
        q12.push_back(ref_model(12, 64'(b12.in_a), 64'(b12.in_b), b12.in_cin, b12.in_sub));
    end
  end

  // Single beat into an empty 64-bit pipe; checks latency and result.
  task automatic send_exp(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input logic sub, input logic [65:0] exp);
    int n;
    tick();
    b64.in_valid = 1'b1; b64.in_a = a; b64.in_b = b; b64.in_cin = cin; b64.in_sub = sub;
    @(negedge clk);
    check({tag, "_rdy"}, 66'(b64.in_ready), 66'd1);
    tick();
    b64.in_valid = 1'b0;
    n = 0;
    while (!b64.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 66'(n), 66'd4);
    check(tag, {b64.out_ovf, b64.out_cout, b64.out_sum}, exp);
  endtask

  initial begin : wdog
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [63:0] ba[8], bb[8];
    logic        bc[8], bs[8];
    int          idx, lat, n;
    logic [63:0] ta, tb;

    rst = 1'b1;
    b64.in_valid = 1'b1; b64.in_a = 64'h1234_5678_9abc_def0; b64.in_b = 64'h0fed_cba9_8765_4321;
    b64.in_cin = 1'b0; b64.in_sub = 1'b0; b64.out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_valid", 66'(b64.out_valid), 66'd0);
      check("rst_sum", 66'(b64.out_sum), 66'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 66'(b64.in_ready), 66'd1);
    tick();
    b64.in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!b64.out_valid && lat < 20);
    check("first_latency", 66'(lat), 66'd4);

    send_exp("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, {1'b0, 1'b1, 64'd0});
    send_exp("sub_0_1", 64'd0, 64'd1, 1'b0, 1'b1, {1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
    send_exp("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, {1'b1, 1'b0, 64'h8000_0000_0000_0000});
    send_exp("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, {1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF});
    send_exp("sub_borrow", 64'd5, 64'd5, 1'b1, 1'b1, {1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF});

    // Backpressure: 8 back-to-back beats, out_ready low in cycles 6..8.
    for (int i = 0; i < 8; i++) begin
      ba[i] = {$urandom, $urandom}; bb[i] = {$urandom, $urandom};
      bc[i] = 1'($urandom); bs[i] = 1'($urandom);
    end
    idx = 0;
    tick();
    for (int cyc = 1; cyc <= 40 && (idx < 8 || q64.size() != 0); cyc++) begin
      b64.out_ready = !(cyc >= 6 && cyc <= 8);
      b64.in_valid  = (idx < 8);
      if (idx < 8) begin
        b64.in_a = ba[idx]; b64.in_b = bb[idx]; b64.in_cin = bc[idx]; b64.in_sub = bs[idx];
      end
      @(negedge clk);
      if (cyc <= 10) check("bp_in_ready", 66'(b64.in_ready), 66'(!(cyc >= 6 && cyc <= 8)));
      if (b64.in_valid && b64.in_ready) idx++;
      tick();
    end
    b64.in_valid = 1'b0; b64.out_ready = 1'b1;
    check("bp_accepted", 66'(idx), 66'd8);
    check("bp_drained", 66'(q64.size()), 66'd0);

    // Reset with three beats in flight: nothing may emerge afterwards.
    for (int i = 0; i < 3; i++) begin
      b64.in_valid = 1'b1; b64.in_a = {$urandom, $urandom}; b64.in_b = {$urandom, $urandom};
      tick();
    end
    b64.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("midrst_quiet", 66'(b64.out_valid), 66'd0);
    end
    ta = {$urandom, $urandom}; tb = {$urandom, $urandom};
    send_exp("post_rst", ta, tb, 1'b1, 1'b1, ref_model(64, ta, tb, 1'b1, 1'b1));

    // Random traffic with random backpressure.
    for (int cyc = 0; cyc < 600; cyc++) begin
      tick();
      b64.in_valid  = ($urandom_range(0, 3) != 0);
      b64.in_a      = {$urandom, $urandom};
      b64.in_b      = {$urandom, $urandom};
      b64.in_cin    = 1'($urandom);
      b64.in_sub    = 1'($urandom);
      b64.out_ready = ($urandom_range(0, 3) != 0);
    end
    tick();
    b64.in_valid = 1'b0; b64.out_ready = 1'b1;
    n = 0;
    while (q64.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("r64_drained", 66'(q64.size()), 66'd0);

    wait (done8 && done12);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : s8
    logic [7:0] cv[4];
    int n, cyc;
    cv[0] = 8'h00; cv[1] = 8'h7F; cv[2] = 8'h80; cv[3] = 8'hFF;
    rst8 = 1'b1; b8.in_valid = 1'b0; b8.in_a = '0; b8.in_b = '0;
    b8.in_cin = 1'b0; b8.in_sub = 1'b0; b8.out_ready = 1'b1;
    repeat (2) tick();
    rst8 = 1'b0;
    n = 0; cyc = 0;
    while (n < 3000 && cyc < 20000) begin
      if (n < 64) begin
        b8.in_valid = 1'b1;
        b8.in_a = cv[n % 4]; b8.in_b = cv[(n / 4) % 4];
        b8.in_cin = 1'((n / 16) % 2); b8.in_sub = 1'((n / 32) % 2);
      end else begin
        b8.in_valid = ($urandom_range(0, 3) != 0);
        b8.in_a = 8'($urandom); b8.in_b = 8'($urandom);
        b8.in_cin = 1'($urandom); b8.in_sub = 1'($urandom);
      end
      b8.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (b8.in_valid && b8.in_ready) n++;
      tick();
      cyc++;
    end
    b8.in_valid = 1'b0; b8.out_ready = 1'b1;
    repeat (5) tick();
    check("s8_beats", 66'(n), 66'd3000);
    check("s8_drained", 66'(q8.size()), 66'd0);
    done8 = 1'b1;
  end

  initial begin : s12
    int n, cyc;
    rst12 = 1'b1; b12.in_valid = 1'b0; b12.in_a = '0; b12.in_b = '0;
    b12.in_cin = 1'b0; b12.in_sub = 1'b0; b12.out_ready = 1'b1;
    repeat (2) tick();
    rst12 = 1'b0;
    n = 0; cyc = 0;
    while (n < 10000 && cyc < 40000) begin
      b12.in_valid  = ($urandom_range(0, 7) != 0);
      b12.in_a      = 12'($urandom);
      b12.in_b      = 12'($urandom);
      b12.in_cin    = 1'($urandom);
      b12.in_sub    = 1'($urandom);
      b12.out_ready = ($urandom_range(0, 7) != 0);
      @(negedge clk);
      if (b12.in_valid && b12.in_ready) n++;
      tick();
      cyc++;
    end
    b12.in_valid = 1'b0; b12.out_ready = 1'b1;
    repeat (8) tick();
    check("s12_beats", 66'(n), 66'd10000);
    check("s12_drained", 66'(q12.size()), 66'd0);
    done12 = 1'b1;
  end

endmodule
